alu_mc: RTL

//  Parametrised, registered successor of the 32-bit combinational ALU.
//  - Adds valid/ready handshakes on input and output.
//  - Adds barrel shifts and an iterative shift-add multiply.
//  - Result and c/n/z/v flags are held in an output register until consumed.
//  - Sits between the register-file read stage and the write-back stage.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_serial.sv | 53 +++++
 rtl/alu_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_NOTA = 4'h0;
   localparam logic [3:0] OP_NOTB = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_XNOR = 4'h5;
   localparam logic [3:0] OP_ADD  = 4'h6;
   localparam logic [3:0] OP_SUB  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_SAR  = 4'hA;
   localparam logic [3:0] OP_MUL  = 4'hB;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mul_serial.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
module alu_mul_serial #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (start) begin
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_acc    <= '0;
         r_cnt    <= CW'(WIDTH);
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt != '0) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   // done is the cycle after the last step; the consumer captures product on that edge.
   assign busy    = r_busy;
   assign done    = r_busy && (r_cnt == '0);
   assign product = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes, barrel shifts and a serial multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             n,
   output logic             z,
   output logic             v,
   output state_e           dbg_state
);

   localparam int SHW = $clog2(WIDTH);

   state_e             r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_c, r_n, r_z, r_v;

   logic [SHW-1:0]     w_sh;
   logic [WIDTH:0]     w_add, w_sub, w_shl, w_shr, w_sar;
   logic [WIDTH-1:0]   w_res;
   logic               w_c, w_v;
   logic               w_accept, w_mul_start, w_mul_busy, w_mul_done;
   logic [2*WIDTH-1:0] w_prod;

   assign w_sh  = b[SHW-1:0];
   assign w_add = {1'b0, a} + {1'b0, b};
   assign w_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   // Shifts run one bit wider so the last bit shifted out lands in a fixed slot.
   assign w_shl = {1'b0, a} << w_sh;
   assign w_shr = {a, 1'b0} >> w_sh;
   assign w_sar = $signed({a, 1'b0}) >>> w_sh;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         OP_NOTA: w_res = ~a;
         OP_NOTB: w_res = ~b;
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_XNOR: w_res = ~(a ^ b);
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = w_add[WIDTH] ^ (a[WIDTH-1] ^ b[WIDTH-1] ^ w_add[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = w_sub[WIDTH] ^ (a[WIDTH-1] ^ ~b[WIDTH-1] ^ w_sub[WIDTH-1]);
         end
         OP_SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         OP_SAR: begin
            w_res = w_sar[WIDTH:1];
            w_c   = w_sar[0];
         end
         default: ;
      endcase
   end

   assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_mul_start = w_accept && (op == OP_MUL);

   alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (w_mul_start),
      .a       (a),
      .b       (b),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_prod)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_c         <= 1'b0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
         r_v         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mul_start) begin
                  r_state     <= ST_MUL;
                  r_out_valid <= 1'b0;
               end else if (w_accept) begin
                  r_result    <= w_res;
                  r_c         <= w_c;
                  r_n         <= w_res[WIDTH-1];
                  r_z         <= (w_res == '0);
                  r_v         <= w_v;
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_result    <= w_prod[WIDTH-1:0];
                  r_c         <= 1'b0;
                  r_n         <= w_prod[WIDTH-1];
                  r_z         <= (w_prod[WIDTH-1:0] == '0);
                  r_v         <= (w_prod[2*WIDTH-1:WIDTH] != '0);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign c         = r_c;
   assign n         = r_n;
   assign z         = r_z;
   assign v         = r_v;
   assign dbg_state = r_state;

endmodule
